// File: rtl/lane_tx_scheduler.sv
// lane_tx_scheduler: link training then round-robin 4-lane byte scheduling with IDLE fill and COM skips (clk_4f/reset, lane data/valid/ready in, registered data/k/valid/lane out, state_out)
module lane_tx_scheduler #(
  parameter int TRAIN_LEN = 4,
  parameter int SKP_PERIOD = 16,
  parameter logic [7:0] COM = 8'hBC,
  parameter logic [7:0] IDL = 8'h7C
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic       active,
  input  logic [7:0] data_in0,
  input  logic [7:0] data_in1,
  input  logic [7:0] data_in2,
  input  logic [7:0] data_in3,
  input  logic       valid0,
  input  logic       valid1,
  input  logic       valid2,
  input  logic       valid3,
  output logic       ready0,
  output logic       ready1,
  output logic       ready2,
  output logic       ready3,
  output logic [7:0] data_out,
  output logic       k_out,
  output logic       valid_out,
  output logic [1:0] lane_out,
  output logic [1:0] state_out
);
  typedef enum logic [1:0] {RST = 2'd0, TRAIN = 2'd1, ACTIVE = 2'd2, WAIT = 2'd3} state_t;
  state_t state, nstate;
  logic [7:0] din [4];
  logic [7:0] hold [4];
  logic [3:0] valid, ready, full, acc, clr;
  logic [7:0] tcnt, scnt, d_nxt;
  logic [1:0] ptr, gl;
  logic found, skp, gnt;
  assign din = '{data_in0, data_in1, data_in2, data_in3};
  assign valid = {valid3, valid2, valid1, valid0};
  assign ready = {4{state == ACTIVE}} & ~full;
  assign {ready3, ready2, ready1, ready0} = ready;
  assign acc = ready & valid;
  assign state_out = state;
  always_comb begin
    found = 1'b0;
    gl = ptr;
    for (int i = 4; i >= 1; i--)
      if (full[ptr + 2'(i)]) begin
        found = 1'b1;
        gl = ptr + 2'(i);
      end
    skp = state == ACTIVE && scnt == 8'(SKP_PERIOD - 1);
    gnt = state == ACTIVE && !skp && found;
    clr = gnt ? 4'b0001 << gl : 4'b0000;
    nstate = state == RST ? TRAIN : state == TRAIN && tcnt != 8'(TRAIN_LEN - 1) ? TRAIN : active ? ACTIVE : WAIT;
    d_nxt = state == RST ? 8'h00 : state == TRAIN || skp ? COM : gnt ? hold[gl] : IDL;
  end
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state <= RST;
      full <= '0;
      tcnt <= '0;
      scnt <= '0;
      ptr <= 2'd3;
      data_out <= '0;
      k_out <= 1'b0;
      valid_out <= 1'b0;
      lane_out <= '0;
    end else begin
      state <= nstate;
      full <= (full & ~clr) | acc;
      tcnt <= state == TRAIN ? tcnt + 8'd1 : 8'd0;
      scnt <= state == ACTIVE ? (skp ? 8'd0 : scnt + 8'd1) : state == WAIT ? scnt : 8'd0;
      ptr <= gnt ? gl : ptr;
      data_out <= d_nxt;
      k_out <= state != RST && !gnt;
      valid_out <= gnt;
      lane_out <= gnt ? gl : lane_out;
    end
  end
  always_ff @(posedge clk_4f)
    for (int n = 0; n < 4; n++)
      if (acc[n]) hold[n] <= din[n];
endmodule

// File: tb/tb_lane_tx_scheduler.sv
// tb_lane_tx_scheduler: directed self-checking bench for lane_tx_scheduler
module tb_lane_tx_scheduler;
  logic clk_4f = 1'b0, reset = 1'b1, active = 1'b1;
  logic [7:0] data_in0 = '0, data_in1 = '0, data_in2 = '0, data_in3 = '0;
  logic valid0 = 1'b0, valid1 = 1'b0, valid2 = 1'b0, valid3 = 1'b0;
  logic ready0, ready1, ready2, ready3, k_out, valid_out;
  logic [7:0] data_out;
  logic [1:0] lane_out, state_out;
  logic [3:0] rdy;
  logic [7:0] pb [4] = '{8'h00, 8'hFD, 8'hAA, 8'h12};
  logic [7:0] e1, e3;
  logic [1:0] last;
  logic a1, a3;
  int n1 = 0, n3 = 0;
  int nchk = 0, npass = 0;
  assign rdy = {ready3, ready2, ready1, ready0};
  lane_tx_scheduler dut (
    .clk_4f(clk_4f), .reset(reset), .active(active),
    .data_in0(data_in0), .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3),
    .valid0(valid0), .valid1(valid1), .valid2(valid2), .valid3(valid3),
    .ready0(ready0), .ready1(ready1), .ready2(ready2), .ready3(ready3),
    .data_out(data_out), .k_out(k_out), .valid_out(valid_out),
    .lane_out(lane_out), .state_out(state_out)
  );
  always #5 clk_4f = ~clk_4f;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk_4f);
    #1;
  endtask
  initial begin
    tick;
    tick;
    chk("rst_state", 32'(state_out), 0);
    chk("rst_data", 32'(data_out), 0);
    chk("rst_k", 32'(k_out), 0);
    chk("rst_valid", 32'(valid_out), 0);
    chk("rst_lane", 32'(lane_out), 0);
    chk("rst_ready", 32'(rdy), 0);
    reset = 1'b0;
    tick;
    chk("rst_exit_state", 32'(state_out), 1);
    chk("rst_exit_data", 32'(data_out), 0);
    chk("rst_exit_ready", 32'(rdy), 0);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("train_com", 32'(data_out), 32'h BC);
      chk("train_k", 32'(k_out), 1);
      chk("train_valid", 32'(valid_out), 0);
      chk("train_state", 32'(state_out), i < 3 ? 1 : 2);
      chk("train_ready", 32'(rdy), i < 3 ? 0 : 32'hF);
    end
    for (int c = 1; c <= 32; c++) begin
      tick;
      chk("idle_data", 32'(data_out), c % 16 == 0 ? 32'hBC : 32'h7C);
      chk("idle_k", 32'(k_out), 1);
      chk("idle_valid", 32'(valid_out), 0);
    end
    data_in0 = pb[0];
    data_in1 = pb[1];
    data_in2 = pb[2];
    data_in3 = pb[3];
    {valid3, valid2, valid1, valid0} = 4'hF;
    tick;
    {valid3, valid2, valid1, valid0} = 4'h0;
    chk("push_ready", 32'(rdy), 0);
    chk("push_gap", 32'(data_out), 32'h7C);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("push_data", 32'(data_out), 32'(pb[i]));
      chk("push_lane", 32'(lane_out), i);
      chk("push_valid", 32'(valid_out), 1);
      chk("push_k", 32'(k_out), 0);
    end
    tick;
    chk("push_idle", 32'(data_out), 32'h7C);
    chk("push_idle_k", 32'(k_out), 1);
    chk("push_idle_valid", 32'(valid_out), 0);
    chk("push_lane_hold", 32'(lane_out), 3);
    data_in2 = 8'h22;
    valid2 = 1'b1;
    tick;
    valid2 = 1'b0;
    tick;
    chk("pre_data", 32'(data_out), 32'h22);
    chk("pre_lane", 32'(lane_out), 2);
    data_in2 = 8'h11;
    data_in3 = 8'h33;
    valid2 = 1'b1;
    valid3 = 1'b1;
    tick;
    valid2 = 1'b0;
    valid3 = 1'b0;
    active = 1'b0;
    tick;
    chk("last_act_data", 32'(data_out), 32'h33);
    chk("last_act_lane", 32'(lane_out), 3);
    chk("last_act_state", 32'(state_out), 3);
    chk("last_act_ready", 32'(rdy), 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("wait_data", 32'(data_out), 32'h7C);
      chk("wait_k", 32'(k_out), 1);
      chk("wait_valid", 32'(valid_out), 0);
      chk("wait_state", 32'(state_out), 3);
      chk("wait_ready", 32'(rdy), 0);
      chk("wait_lane", 32'(lane_out), 3);
    end
    active = 1'b1;
    tick;
    chk("resume_state", 32'(state_out), 2);
    chk("resume_gap", 32'(data_out), 32'h7C);
    tick;
    chk("resume_data", 32'(data_out), 32'h11);
    chk("resume_lane", 32'(lane_out), 2);
    chk("resume_valid", 32'(valid_out), 1);
    data_in1 = 8'h10;
    data_in3 = 8'h30;
    e1 = 8'h10;
    e3 = 8'h30;
    last = 2'd1;
    valid1 = 1'b1;
    valid3 = 1'b1;
    for (int i = 0; i < 44; i++) begin
      a1 = ready1 & valid1;
      a3 = ready3 & valid3;
      tick;
      if (a1) begin
        data_in1 = data_in1 + 8'd1;
        n1++;
      end
      if (a3) begin
        data_in3 = data_in3 + 8'd1;
        n3++;
      end
      if (i == 39) begin
        valid1 = 1'b0;
        valid3 = 1'b0;
      end
      if (valid_out) begin
        chk("alt_lane", 32'(lane_out), last == 2'd1 ? 3 : 1);
        last = lane_out;
        if (lane_out == 2'd1) begin
          chk("l1_byte", 32'(data_out), 32'(e1));
          e1 = e1 + 8'd1;
        end else if (lane_out == 2'd3) begin
          chk("l3_byte", 32'(data_out), 32'(e3));
          e3 = e3 + 8'd1;
        end
      end
    end
    chk("l1_count", 32'(e1 - 8'h10), 32'(n1));
    chk("l3_count", 32'(e3 - 8'h30), 32'(n3));
    chk("l1_thru", 32'(n1 >= 15), 1);
    chk("l3_thru", 32'(n3 >= 15), 1);
    chk("pre_rst_ready", 32'(rdy), 32'hF);
    data_in0 = 8'hA0;
    data_in2 = 8'hA2;
    valid0 = 1'b1;
    valid2 = 1'b1;
    tick;
    valid0 = 1'b0;
    valid2 = 1'b0;
    reset = 1'b1;
    tick;
    chk("mid_rst_state", 32'(state_out), 0);
    chk("mid_rst_data", 32'(data_out), 0);
    chk("mid_rst_valid", 32'(valid_out), 0);
    chk("mid_rst_ready", 32'(rdy), 0);
    reset = 1'b0;
    tick;
    chk("retrain_state", 32'(state_out), 1);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("retrain_com", 32'(data_out), 32'hBC);
      chk("retrain_state", 32'(state_out), i < 3 ? 1 : 2);
    end
    for (int i = 0; i < 8; i++) begin
      tick;
      chk("post_rst_valid", 32'(valid_out), 0);
      chk("post_rst_data", 32'(data_out), 32'h7C);
    end
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
